// File: rtl/ram_single_pkg.sv
// ram_single_pkg
// Shared geometry defaults, word/address types and read latency for the
// single-port RAM. Build option RAM_SINGLE_OUT_REG_EN adds an output
// pipeline stage, so the read latency becomes 2 instead of 1.
package ram_single_pkg;

    localparam int DATA_W = 2;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

`ifdef RAM_SINGLE_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/ram_single_array.sv
// ram_single_array
// Reset-free storage core: synchronous write and a read-first registered read.
// It has no reset, so synthesis can map it straight onto block RAM.
// Ports:
//   clk   - clock
//   en    - port enable (gates both write and read register)
//   we    - write enable, qualified by en
//   addr  - shared word address
//   din   - write data
//   dout  - read register (contents before any same-edge write)
module ram_single_array #(
    parameter int DATA_W = ram_single_pkg::DATA_W,
    parameter int ADDR_W = ram_single_pkg::ADDR_W,
    parameter int DEPTH  = ram_single_pkg::DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Power-up contents; synthesis turns this into the BRAM init image.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = INIT_VAL;
        end
    end

    // Read-first: dout captures the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_single_port.sv
// ram_single_port
// Single-port synchronous RAM (default 16384 x 2). One shared address for
// write and read, read-first, registered output with async active-low clear.
// Build option RAM_SINGLE_OUT_REG_EN adds a second output register
// (read latency 2); without it the read latency is 1.
// Ports:
//   clka  - clock, all state changes on its rising edge
//   rsta  - asynchronous active-low reset (clears douta, not the array)
//   ena   - port enable; 0 = no write and douta holds
//   wea   - write enable, qualified by ena
//   addra - word address for write and read
//   dina  - write data
//   douta - registered read data
module ram_single_port #(
    parameter int DATA_W = ram_single_pkg::DATA_W,
    parameter int ADDR_W = ram_single_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    import ram_single_pkg::*;

    logic              arr_en;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid;
    logic [DATA_W-1:0] stage1;

    // Holding rsta low freezes the array, so a write on an edge that sees
    // reset asserted never lands.
    assign arr_en = ena & rsta;

    ram_single_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) u_array (
        .clk  (clka),
        .en   (arr_en),
        .we   (wea),
        .addr (addra),
        .din  (dina),
        .dout (rd_q)
    );

    // The BRAM read register cannot be reset, so a resettable flag masks it:
    // the output reads 0 from reset until the first enabled edge refreshes
    // the read register, which gives the async clear without touching BRAM.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            rd_valid <= 1'b0;
        end else if (ena) begin
            rd_valid <= 1'b1;
        end
    end

    assign stage1 = rd_valid ? rd_q : '0;

`ifdef RAM_SINGLE_OUT_REG_EN
    logic [DATA_W-1:0] pipe_q;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            pipe_q <= '0;
        end else if (ena) begin
            pipe_q <= stage1;
        end
    end

    assign douta = pipe_q;
`else
    assign douta = stage1;
`endif

endmodule

// File: tb/tb_ram_single_port.sv
module tb_ram_single_port;
    import ram_single_pkg::*;

    logic        clka;
    logic        rsta;
    logic        ena;
    logic        wea;
    logic [13:0] addra;
    logic [1:0]  dina;
    logic [1:0]  douta;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] model [16384];
    logic [1:0] exp_q [$];
    logic [1:0] last_exp;

    ram_single_port dut (
        .clka  (clka),
        .rsta  (rsta),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, update model at the edge, check #1 after.
    task automatic step(input string tag, input logic e, input logic w,
                        input logic [13:0] a, input logic [1:0] d);
        @(negedge clka);
        ena = e; wea = w; addra = a; dina = d;
        @(posedge clka);
        #1;
        if (rsta && e) begin
            exp_q.push_back(model[a]);
            if (w) model[a] = d;
        end
        if (rsta && e && exp_q.size() >= RD_LAT) begin
            last_exp = exp_q.pop_front();
            check(tag, douta, last_exp);
        end else begin
            check({tag, "_hold"}, douta, last_exp);
        end
    endtask

    initial begin
        logic [13:0] ra;
        logic [1:0]  rd;
        for (int i = 0; i < 16384; i++) model[i] = 2'b00;
        last_exp = 2'b00;
        rsta = 1'b0; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        #1;
        check("reset_out", douta, 2'b00);
        repeat (2) @(posedge clka);
        @(negedge clka);
        rsta = 1'b1;

        // basic write/read
        step("wr0", 1, 1, 14'd0, 2'b01);
        step("wr4", 1, 1, 14'd4, 2'b10);
        step("rd0", 1, 0, 14'd0, 2'b00);
        step("rd4", 1, 0, 14'd4, 2'b10);

        // read-first
        step("wr100", 1, 1, 14'd100, 2'b11);
        step("rf100", 1, 1, 14'd100, 2'b00);
        step("rd100", 1, 0, 14'd100, 2'b00);

        // boundaries
        step("wr_lo", 1, 1, 14'h0000, 2'b10);
        step("wr_hi", 1, 1, 14'h3FFF, 2'b01);
        step("rd_lo", 1, 0, 14'h0000, 2'b00);
        step("rd_hi", 1, 0, 14'h3FFF, 2'b00);
        step("rd_mid", 1, 0, 14'h2000, 2'b00);
        step("rd_mid2", 1, 0, 14'h2000, 2'b00);

        // disabled port: no write, output holds
        step("dis_a", 0, 1, 14'd7, 2'b11);
        step("dis_b", 0, 1, 14'd7, 2'b11);
        step("rd7", 1, 0, 14'd7, 2'b00);
        step("rd7b", 1, 0, 14'd7, 2'b00);

        // get 11 on the output, then reset mid-cycle
        step("wr200", 1, 1, 14'd200, 2'b11);
        step("rd200", 1, 0, 14'd200, 2'b00);
        step("rd200b", 1, 0, 14'd200, 2'b00);
        check("pre_rst", douta, 2'b11);
        @(posedge clka);
        #3;
        rsta = 1'b0;
        #1;
        check("async_clr", douta, 2'b00);
        exp_q.delete();
        last_exp = 2'b00;
        step("rst_wr50", 1, 1, 14'd50, 2'b11);
        step("rst_b", 1, 0, 14'd200, 2'b00);
        step("rst_c", 0, 0, 14'd200, 2'b00);
        @(negedge clka);
        rsta = 1'b1;
        step("persist200", 1, 0, 14'd200, 2'b00);
        step("sup50", 1, 0, 14'd50, 2'b00);
        step("sup50b", 1, 0, 14'd50, 2'b00);

        // random write-then-read
        for (int k = 0; k < 1000; k++) begin
            ra = 14'($urandom_range(16383));
            rd = 2'($urandom_range(3));
            step("rnd_wr", 1, 1, ra, rd);
            step("rnd_rd", 1, 0, ra, 2'b00);
        end
        step("drain", 1, 0, 14'd0, 2'b00);
        step("drain2", 1, 0, 14'd0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
